// File: rtl/rns_err_monitor.sv
`timescale 1ns/1ps
// ============================================================================
// rns_err_monitor
// ----------------------------------------------------------------------------
// Error-response controller that sits behind the registered residue-check
// error-flag OR stage of the TPU datapath.
//
// Clean results are committed with a one-cycle ok_out pulse. An erroring
// result requests a re-issue of the operation over a retry_req/retry_ack
// handshake. The controller then waits, with a timeout, for the retried
// result. If the retries run out, or the retried result never arrives, it
// parks in a sticky FAULT state. A saturating error counter is kept for the
// host to read.
//
// Handshake: retry_req rises one cycle after the erroring result is sampled.
// It stays high until the first clock edge that samples retry_ack high, and
// it drops on that same edge. An ack seen on the first cycle of retry_req is
// accepted. retry_ack is ignored while retry_req is low.
//
// Optional feature (macro ERR_IRQ_EN): irq pulses for one cycle on the edge
// where err_count becomes IRQ_THRESH. When the macro is not defined, irq is
// tied to 0 and IRQ_THRESH is unused.
//
// Parameters:
//   CNT_W        width of the saturating error counter
//   MAX_RETRY    retries allowed per operation (0..15); 0 -> fault on any error
//   WAIT_TIMEOUT cycles allowed in WAIT for a retried result (1..255)
//   IRQ_THRESH   err_count value that fires irq (ERR_IRQ_EN builds only)
//
// Ports:
//   clk         clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   valid_in    a result is present this cycle
//   err_in      combined residue-check error flag, qualified by valid_in
//   retry_ack   upstream accepted the re-issue request
//   clr         synchronous clear of fault, sticky flag, counters and state
//   ok_out      one-cycle pulse, a result committed error-free
//   retry_req   re-issue request, held until acked
//   err_sticky  set on any counted error
//   fault       unrecoverable error, sticky until clr or reset
//   busy        state is not IDLE
//   err_count   saturating count of erroneous results
//   retry_cnt   retries used for the current operation
//   irq         threshold pulse (constant 0 without ERR_IRQ_EN)
// ============================================================================
module rns_err_monitor #(
    parameter int CNT_W        = 16,
    parameter int MAX_RETRY    = 3,
    parameter int WAIT_TIMEOUT = 64,
    parameter int IRQ_THRESH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             err_in,
    input  logic             retry_ack,
    input  logic             clr,
    output logic             ok_out,
    output logic             retry_req,
    output logic             err_sticky,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       retry_cnt,
    output logic             irq
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RETRY_REQ = 2'd1,
        ST_WAIT      = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    localparam logic [3:0]       MAX_R   = 4'(MAX_RETRY);
    localparam logic [7:0]       WAIT_TO = 8'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // state is kept as a named internal signal so checkers can bind to it.
    state_t           state;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_event;

    // An error is counted only in IDLE or WAIT. In RETRY_REQ the results are
    // stale in-flight data, and in FAULT they are ignored. clr drops the
    // result.
    assign err_event = valid_in && err_in && !clr &&
                       ((state == ST_IDLE) || (state == ST_WAIT));

    // Saturating increment: the counter holds at all-ones and never wraps.
    assign cnt_inc = (err_count == CNT_MAX) ? err_count
                                            : err_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            ok_out     <= 1'b0;
            retry_req  <= 1'b0;
            err_sticky <= 1'b0;
            fault      <= 1'b0;
            busy       <= 1'b0;
            err_count  <= '0;
            retry_cnt  <= '0;
        end else begin
            ok_out <= 1'b0;

            if (clr) begin
                state      <= ST_IDLE;
                wait_cnt   <= '0;
                retry_req  <= 1'b0;
                err_sticky <= 1'b0;
                fault      <= 1'b0;
                busy       <= 1'b0;
                err_count  <= '0;
                retry_cnt  <= '0;
            end else begin
                if (err_event) begin
                    err_count  <= cnt_inc;
                    err_sticky <= 1'b1;
                end

                // busy tracks the state register, so it is loaded with the
                // next-state value alongside every state update below.
                case (state)
                    ST_IDLE: begin
                        if (valid_in && !err_in) begin
                            ok_out <= 1'b1;
                        end else if (valid_in && err_in) begin
                            busy <= 1'b1;
                            if (MAX_R == 4'd0) begin
                                state <= ST_FAULT;
                                fault <= 1'b1;
                            end else begin
                                state     <= ST_RETRY_REQ;
                                retry_req <= 1'b1;
                                retry_cnt <= 4'd1;
                            end
                        end
                    end

                    ST_RETRY_REQ: begin
                        if (retry_ack) begin
                            state     <= ST_WAIT;
                            retry_req <= 1'b0;
                            wait_cnt  <= '0;
                        end
                    end

                    ST_WAIT: begin
                        // The counter starts at 0 on the ack edge. The
                        // timeout fires on the edge that sees it already at
                        // WAIT_TIMEOUT, which is WAIT_TIMEOUT+1 edges after
                        // the ack.
                        if (valid_in && !err_in) begin
                            ok_out    <= 1'b1;
                            retry_cnt <= '0;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end else if (valid_in && err_in) begin
                            if (retry_cnt == MAX_R) begin
                                state <= ST_FAULT;
                                fault <= 1'b1;
                            end else begin
                                retry_cnt <= retry_cnt + 4'd1;
                                state     <= ST_RETRY_REQ;
                                retry_req <= 1'b1;
                            end
                        end else if (wait_cnt == WAIT_TO) begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end

                    ST_FAULT: begin
                        // Terminal until clr or reset. retry_cnt is left
                        // untouched for diagnosis.
                        fault     <= 1'b1;
                        retry_req <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ERR_IRQ_EN
    localparam logic [CNT_W-1:0] IRQ_T = CNT_W'(IRQ_THRESH);

    logic irq_q;

    // Fires only on the edge where the count moves onto the threshold. While
    // the count is saturated it does not change, so the pulse cannot repeat.
    // clr zeroes the count, which re-arms the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= err_event && (err_count != IRQ_T) && (cnt_inc == IRQ_T);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_rns_err_monitor.sv
`timescale 1ns/1ps
// Directed testbench for rns_err_monitor.
// The stimulus tasks push the expected output events into exp_q. Each event
// carries the observation cycle, the kind, retry_cnt and err_count. A monitor
// pops and compares an entry whenever the DUT shows an ok_out pulse, a rising
// retry_req or a rising fault.
module tb_rns_err_monitor;

    localparam int CNT_W        = 3;
    localparam int MAX_RETRY    = 3;
    localparam int WAIT_TIMEOUT = 5;
    localparam int IRQ_THRESH   = 2;
    localparam int W            = 32;

`ifdef ERR_IRQ_EN
    localparam int EXP_IRQ = 1;
`else
    localparam int EXP_IRQ = 0;
`endif

    localparam logic [3:0] K_NONE  = 4'd0;
    localparam logic [3:0] K_OK    = 4'd1;
    localparam logic [3:0] K_RREQ  = 4'd2;
    localparam logic [3:0] K_FAULT = 4'd3;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic             err_in;
    logic             retry_ack;
    logic             clr;
    logic             ok_out;
    logic             retry_req;
    logic             err_sticky;
    logic             fault;
    logic             busy;
    logic [CNT_W-1:0] err_count;
    logic [3:0]       retry_cnt;
    logic             irq;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;
    int           cyc;
    int           irq_seen;

    rns_err_monitor #(
        .CNT_W       (CNT_W),
        .MAX_RETRY   (MAX_RETRY),
        .WAIT_TIMEOUT(WAIT_TIMEOUT),
        .IRQ_THRESH  (IRQ_THRESH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .err_in    (err_in),
        .retry_ack (retry_ack),
        .clr       (clr),
        .ok_out    (ok_out),
        .retry_req (retry_req),
        .err_sticky(err_sticky),
        .fault     (fault),
        .busy      (busy),
        .err_count (err_count),
        .retry_cnt (retry_cnt),
        .irq       (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input int c, input logic [3:0] kind,
                                        input logic [3:0] rc, input int cnt);
        return {16'(c), kind, rc, 8'(cnt)};
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({ok_out, retry_req, err_sticky, fault, busy, err_count, retry_cnt, irq});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic drive_valid(input logic err, input logic [3:0] kind,
                               input logic [3:0] rc, input int cnt);
        valid_in = 1'b1;
        err_in   = err;
        if (kind != K_NONE) exp_q.push_back(mk(cyc + 1, kind, rc, cnt));
        @(negedge clk);
        valid_in = 1'b0;
        err_in   = 1'b0;
    endtask

    task automatic do_ack(input int extra);
        for (int i = 0; i < 20 && !retry_req; i++) @(negedge clk);
        chk("ack_wait_retry_req", 32'(retry_req), 32'd1);
        repeat (extra) @(negedge clk);
        retry_ack = 1'b1;
        @(negedge clk);
        retry_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        irq_seen = 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic         prev_rr;
    logic         prev_f;
    logic [3:0]   ev_kind;
    logic [W-1:0] ev;
    logic [W-1:0] exp_ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rr = 1'b0;
            prev_f  = 1'b0;
        end else begin
            ev_kind = K_NONE;
            if (ok_out)                      ev_kind = K_OK;
            else if (retry_req && !prev_rr)  ev_kind = K_RREQ;
            else if (fault && !prev_f)       ev_kind = K_FAULT;
            if (ev_kind != K_NONE) begin
                ev = mk(cyc, ev_kind, retry_cnt, int'(err_count));
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event: got %0h expected none", ev);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (ev !== exp_ev) begin
                        n_errors++;
                        $display("FAIL event: got %0h expected %0h", ev, exp_ev);
                    end
                end
            end
            if (irq) begin
                irq_seen++;
                n_checks++;
                if (err_count !== CNT_W'(IRQ_THRESH)) begin
                    n_errors++;
                    $display("FAIL irq_count: got %0d expected %0d", err_count, IRQ_THRESH);
                end
            end
            prev_rr = retry_req;
            prev_f  = fault;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        irq_seen  = 0;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        err_in    = 1'b0;
        retry_ack = 1'b0;
        clr       = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean stream: ten back-to-back good results.
        for (int i = 0; i < 10; i++) drive_valid(1'b0, K_OK, 4'd0, 0);
        @(negedge clk);
        chk("clean_busy", 32'(busy), 32'd0);
        chk("clean_retry_req", 32'(retry_req), 32'd0);
        chk("clean_fault", 32'(fault), 32'd0);
        chk("clean_err_count", 32'(err_count), 32'd0);

        // An ack with no request pending is ignored.
        retry_ack = 1'b1;
        @(negedge clk);
        retry_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_retry_req", 32'(retry_req), 32'd0);

        // Single error, ack three cycles later, then a good retried result.
        drive_valid(1'b1, K_RREQ, 4'd1, 1);
        repeat (2) @(negedge clk);
        chk("single_retry_req_held", 32'(retry_req), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        retry_ack = 1'b1;
        @(negedge clk);
        retry_ack = 1'b0;
        chk("single_req_drop", 32'(retry_req), 32'd0);
        drive_valid(1'b0, K_OK, 4'd0, 1);
        @(negedge clk);
        chk("single_busy_idle", 32'(busy), 32'd0);
        chk("single_sticky", 32'(err_sticky), 32'd1);
        chk("single_err_count", 32'(err_count), 32'd1);
        chk("single_retry_cnt", 32'(retry_cnt), 32'd0);

        // Retry exhaustion: four consecutive errors, with err_count starting at 1.
        drive_valid(1'b1, K_RREQ, 4'd1, 2);
        do_ack(1);
        drive_valid(1'b1, K_RREQ, 4'd2, 3);
        do_ack(0);
        drive_valid(1'b1, K_RREQ, 4'd3, 4);
        do_ack(0);
        drive_valid(1'b1, K_FAULT, 4'd3, 5);
        drive_valid(1'b1, K_NONE, 4'd0, 0);
        drive_valid(1'b0, K_NONE, 4'd0, 0);
        retry_ack = 1'b1;
        @(negedge clk);
        retry_ack = 1'b0;
        @(negedge clk);
        chk("exh_fault", 32'(fault), 32'd1);
        chk("exh_err_count", 32'(err_count), 32'd5);
        chk("exh_retry_cnt", 32'(retry_cnt), 32'd3);
        chk("exh_retry_req", 32'(retry_req), 32'd0);
        chk("exh_busy", 32'(busy), 32'd1);
        chk("exh_irq_pulses", 32'(irq_seen), 32'(EXP_IRQ));
        pulse_clr();
        chk("exh_clr_outputs", all_outs(), 32'd0);

        // Timeout: after the ack no result arrives, so fault is expected 6
        // edges after the ack edge.
        drive_valid(1'b1, K_RREQ, 4'd1, 1);
        for (int i = 0; i < 20 && !retry_req; i++) @(negedge clk);
        retry_ack = 1'b1;
        exp_q.push_back(mk(cyc + 1 + WAIT_TIMEOUT + 1, K_FAULT, 4'd1, 1));
        @(negedge clk);
        retry_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("timeout_not_early", 32'(fault), 32'd0);
        repeat (3) @(negedge clk);
        chk("timeout_fault", 32'(fault), 32'd1);
        chk("timeout_err_count", 32'(err_count), 32'd1);
        pulse_clr();

        // Saturation: nine error/good pairs, so err_count stops at 7.
        for (int i = 0; i < 9; i++) begin
            drive_valid(1'b1, K_RREQ, 4'd1, (i + 1 > 7) ? 7 : i + 1);
            do_ack(0);
            drive_valid(1'b0, K_OK, 4'd0, (i + 1 > 7) ? 7 : i + 1);
        end
        chk("sat_err_count", 32'(err_count), 32'd7);
        chk("sat_irq_pulses", 32'(irq_seen), 32'(EXP_IRQ));
        // clr collides with an erroring result, and the result is dropped.
        clr      = 1'b1;
        valid_in = 1'b1;
        err_in   = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        valid_in = 1'b0;
        err_in   = 1'b0;
        irq_seen = 0;
        chk("clr_collide_outputs", all_outs(), 32'd0);
        @(negedge clk);
        chk("clr_collide_no_req", 32'(retry_req), 32'd0);

        // Asynchronous reset in the middle of RETRY_REQ.
        drive_valid(1'b1, K_RREQ, 4'd1, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_req", 32'(retry_req), 32'd0);
        chk("async_reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_valid(1'b0, K_OK, 4'd0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
